mpu_clock_ctrl: RTL and testbench

//  Parametrised 6502 clock generator and bus-cycle monitor sitting between board controls and the MPU pins.

---
 rtl/mpu_ctrl_pkg.sv | 19 +
 rtl/mpu_phase_timer.sv | 38 +++
 rtl/mpu_clock_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mpu_clock_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_ctrl_pkg.sv
// Shared encodings for the 6502 clock generator / bus-cycle monitor.
package mpu_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_e;

  localparam int unsigned CYCLE_CNT_W = 32;

endpackage

// File: rtl/mpu_phase_timer.sv
// Loadable phase down-counter; done_o is high in the clk where the loaded
// number of clks has elapsed, so one instance times both mpu_clk phases.
module mpu_phase_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             done_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > DIV_W'(1)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
    done_d = (cnt_d == DIV_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/mpu_clock_ctrl.sv
// 6502 phi0 generator with halt/run/step/burst modes and per-cycle bus trace.
// Define MPU_CYCLE_COUNT_EN to build the completed-cycle counter.
module mpu_clock_ctrl
  import mpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode_i,
  input  logic [DIV_W-1:0]       half_period_i,
  input  logic                   step_pulse_i,
  input  logic [BURST_W-1:0]     burst_len_i,
  input  logic [ADDR_W-1:0]      addr_bus_i,
  input  logic [DATA_W-1:0]      data_bus_in_i,
  output logic                   mpu_clk_o,
  output logic                   phi_rise_o,
  output logic                   phi_fall_o,
  output logic                   busy_o,
  output logic                   snap_valid_o,
  output logic [ADDR_W-1:0]      snap_addr_o,
  output logic [DATA_W-1:0]      snap_data_o,
  output logic [CYCLE_CNT_W-1:0] cycle_count_o
);

  state_e             state_q, state_d;
  mode_e              mode_w, mode_q, mode_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]   h_q, h_d, h_new, load_val;
  logic               load, done, start;
  logic               clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic               busy_q, busy_d, sv_q, sv_d;
  logic [ADDR_W-1:0]  snap_addr_q, snap_addr_d;
  logic [DATA_W-1:0]  snap_data_q, snap_data_d;

  assign mode_w = mode_e'(mode_i);
  assign h_new  = (half_period_i == '0) ? DIV_W'(1) : half_period_i;

  mpu_phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_val_i (load_val),
    .done_o     (done)
  );

  // Cycle sequencing; the end-of-cycle decision is folded into the falling-edge clk.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    h_d         = h_q;
    load        = 1'b0;
    load_val    = h_q;
    start       = 1'b0;
    clk_d       = clk_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    sv_d        = 1'b0;
    snap_addr_d = snap_addr_q;
    snap_data_d = snap_data_q;

    case (state_q)
      ST_IDLE: begin
        clk_d = 1'b0;
        if (mode_w == MODE_RUN) begin
          start = 1'b1;
        end else if (mode_w == MODE_STEP && step_pulse_i) begin
          start = 1'b1;
          rem_d = BURST_W'(1);
        end else if (mode_w == MODE_BURST && step_pulse_i && burst_len_i != '0) begin
          start = 1'b1;
          rem_d = burst_len_i;
        end
      end
      ST_LOW: begin
        if (done) begin
          clk_d    = 1'b1;
          rise_d   = 1'b1;
          state_d  = ST_HIGH;
          load     = 1'b1;
          load_val = h_q;
        end
      end
      ST_HIGH: begin
        if (done) begin
          clk_d       = 1'b0;
          fall_d      = 1'b1;
          sv_d        = 1'b1;
          snap_addr_d = addr_bus_i;
          snap_data_d = data_bus_in_i;
          if (mode_q == MODE_RUN) begin
            start = (mode_w == MODE_RUN);
          end else begin
            // Leaving BURST, or a finished count, drops whatever remains.
            start = (mode_w == MODE_BURST) && (mode_q == MODE_BURST) && (rem_q > BURST_W'(1));
            rem_d = start ? rem_q - BURST_W'(1) : '0;
          end
          if (!start) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_LOW;
      load     = 1'b1;
      load_val = h_new;
      h_d      = h_new;
      mode_d   = mode_w;
    end

    busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_HALT;
      rem_q       <= '0;
      h_q         <= DIV_W'(1);
      clk_q       <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      busy_q      <= 1'b0;
      sv_q        <= 1'b0;
      snap_addr_q <= '0;
      snap_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rem_q       <= rem_d;
      h_q         <= h_d;
      clk_q       <= clk_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      busy_q      <= busy_d;
      sv_q        <= sv_d;
      snap_addr_q <= snap_addr_d;
      snap_data_q <= snap_data_d;
    end
  end

  assign mpu_clk_o    = clk_q;
  assign phi_rise_o   = rise_q;
  assign phi_fall_o   = fall_q;
  assign busy_o       = busy_q;
  assign snap_valid_o = sv_q;
  assign snap_addr_o  = snap_addr_q;
  assign snap_data_o  = snap_data_q;

`ifdef MPU_CYCLE_COUNT_EN
  logic [CYCLE_CNT_W-1:0] cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= '0;
    end else if (fall_d) begin
      cc_q <= cc_q + CYCLE_CNT_W'(1);
    end
  end

  assign cycle_count_o = cc_q;
`else
  assign cycle_count_o = CYCLE_CNT_W'(0);
`endif

endmodule

// File: tb/tb_mpu_clock_ctrl.sv
// Bench for mpu_clock_ctrl: timeline model of MPU cycles plus directed checks.
module tb_mpu_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] half_period;
  logic        step_pulse;
  logic [7:0]  burst_len;
  logic [15:0] addr_bus;
  logic [7:0]  data_bus_in;
  logic        mpu_clk, phi_rise, phi_fall, busy, snap_valid;
  logic [15:0] snap_addr;
  logic [7:0]  snap_data;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  mpu_clock_ctrl #(.DIV_W(16), .BURST_W(8), .ADDR_W(16), .DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode_i        (mode),
    .half_period_i (half_period),
    .step_pulse_i  (step_pulse),
    .burst_len_i   (burst_len),
    .addr_bus_i    (addr_bus),
    .data_bus_in_i (data_bus_in),
    .mpu_clk_o     (mpu_clk),
    .phi_rise_o    (phi_rise),
    .phi_fall_o    (phi_fall),
    .busy_o        (busy),
    .snap_valid_o  (snap_valid),
    .snap_addr_o   (snap_addr),
    .snap_data_o   (snap_data),
    .cycle_count_o (cycle_count)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Model: each MPU cycle is a timeline of 2H clks measured from its start edge.
  logic        m_clk, m_rise, m_fall, m_busy, m_sv;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic [31:0] m_cc;
  bit          m_active, m_fresh, m_cont;
  int          m_pos, m_h, m_rem, m_kind;

  function automatic int hval();
    return (half_period == 16'd0) ? 1 : int'(half_period);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      {m_clk, m_rise, m_fall, m_busy, m_sv} = '0;
      m_addr = '0; m_data = '0; m_cc = '0;
      m_active = 0; m_pos = 0; m_h = 1; m_rem = 0; m_kind = 0;
    end else begin
      m_rise = 0; m_fall = 0; m_sv = 0; m_fresh = 0;
      if (m_active) begin
        m_pos++;
        if (m_pos == m_h) begin
          m_clk = 1; m_rise = 1;
        end else if (m_pos == 2 * m_h) begin
          m_clk = 0; m_fall = 1; m_sv = 1;
          m_addr = addr_bus; m_data = data_bus_in;
`ifdef MPU_CYCLE_COUNT_EN
          m_cc = m_cc + 32'd1;
`endif
          if (m_kind == 1) begin
            m_cont = (mode == 2'd1);
          end else begin
            m_rem--;
            m_cont = (mode == 2'd3) && (m_kind == 3) && (m_rem > 0);
          end
          if (m_cont) begin m_pos = 0; m_h = hval(); end
          else m_active = 0;
        end
      end else begin
        m_clk = 0;
        if (mode == 2'd1) begin
          m_fresh = 1;
        end else if (mode == 2'd2 && step_pulse) begin
          m_fresh = 1; m_rem = 1;
        end else if (mode == 2'd3 && step_pulse && burst_len != 8'd0) begin
          m_fresh = 1; m_rem = int'(burst_len);
        end
        if (m_fresh) begin
          m_active = 1; m_pos = 0; m_h = hval(); m_kind = int'(mode);
        end
      end
      m_busy = m_active && !m_fresh;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("mpu_clk",     64'(mpu_clk),     64'(m_clk));
    chk("phi_rise",    64'(phi_rise),    64'(m_rise));
    chk("phi_fall",    64'(phi_fall),    64'(m_fall));
    chk("busy",        64'(busy),        64'(m_busy));
    chk("snap_valid",  64'(snap_valid),  64'(m_sv));
    chk("snap_addr",   64'(snap_addr),   64'(m_addr));
    chk("snap_data",   64'(snap_data),   64'(m_data));
    chk("cycle_count", 64'(cycle_count), 64'(m_cc));
  end

  int n_rise = 0, n_fall = 0, t_rise = 0, t_fall = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (phi_rise === 1'b1) begin n_rise++; t_rise = cyc; end
      if (phi_fall === 1'b1) begin n_fall++; t_fall = cyc; end
    end
  endtask

  task automatic wait_edge(input bit fall, input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = fall ? (phi_fall === 1'b1) : (phi_rise === 1'b1);
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  int r1, r2, f1, f2, f3, k, base_r, base_f;
  logic [31:0] cc0;

  initial begin
    rst_n = 1'b0; mode = 2'd0; half_period = 16'd1; step_pulse = 1'b0;
    burst_len = 8'd0; addr_bus = 16'h0000; data_bus_in = 8'h00;
    tick(3);
    chk("rst_mpu_clk", 64'(mpu_clk), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_snap_valid", 64'(snap_valid), 64'd0);
    chk("rst_snap_addr", 64'(snap_addr), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    rst_n = 1'b1;
    tick(3);
    chk("halt_idle_clk", 64'(mpu_clk), 64'd0);

    // RUN with H=3, then H=5 applied mid-high.
    half_period = 16'd3; mode = 2'd1;
    wait_edge(0, 20, "run_rise1"); r1 = t_rise;
    wait_edge(1, 20, "run_fall1"); f1 = t_fall;
    wait_edge(0, 20, "run_rise2"); r2 = t_rise;
    chk("run_high_len", 64'(f1 - r1), 64'd3);
    chk("run_period", 64'(r2 - r1), 64'd6);
    half_period = 16'd5;
    wait_edge(1, 20, "run_fall2"); f2 = t_fall;
    wait_edge(1, 30, "run_fall3"); f3 = t_fall;
    chk("run_high_unchanged", 64'(f2 - r2), 64'd3);
    chk("run_period_h5", 64'(f3 - f2), 64'd10);

    // RUN -> HALT one clk after a rise: exactly one more fall.
    wait_edge(0, 20, "halt_rise");
    base_f = n_fall;
    tick(1); mode = 2'd0;
    tick(20);
    chk("halt_extra_falls", 64'(n_fall - base_f), 64'd1);
    chk("halt_clk_low", 64'(mpu_clk), 64'd0);
    chk("halt_busy", 64'(busy), 64'd0);

    // STEP with H=2; a second request one clk later is ignored.
    half_period = 16'd2; mode = 2'd2;
    tick(2);
    base_r = n_rise; base_f = n_fall;
    k = cyc + 1; step_pulse = 1'b1;
    tick(1);
    chk("step_busy_at_k", 64'(busy), 64'd0);
    tick(1); step_pulse = 1'b0;
    chk("step_busy_k1", 64'(busy), 64'd1);
    tick(12);
    chk("step_rises", 64'(n_rise - base_r), 64'd1);
    chk("step_falls", 64'(n_fall - base_f), 64'd1);
    chk("step_rise_edge", 64'(t_rise), 64'(k + 2));
    chk("step_fall_edge", 64'(t_fall), 64'(k + 4));

    // Step request in HALT is ignored.
    mode = 2'd0; base_r = n_rise;
    step_pulse = 1'b1; tick(1); step_pulse = 1'b0; tick(8);
    chk("halt_step_ignored", 64'(n_rise - base_r), 64'd0);

    // BURST of 4 at H=1, then burst_len=0, then the maximum burst.
    half_period = 16'd1; mode = 2'd3; burst_len = 8'd4;
    base_f = n_fall;
    step_pulse = 1'b1; tick(1); step_pulse = 1'b0;
    tick(20);
    chk("burst4_falls", 64'(n_fall - base_f), 64'd4);
    chk("burst4_idle", 64'(busy), 64'd0);
    burst_len = 8'd0; base_r = n_rise;
    step_pulse = 1'b1; tick(1); step_pulse = 1'b0;
    tick(10);
    chk("burst0_rises", 64'(n_rise - base_r), 64'd0);
    burst_len = 8'hFF; base_f = n_fall;
    step_pulse = 1'b1; tick(1); step_pulse = 1'b0;
    tick(530);
    chk("burst255_falls", 64'(n_fall - base_f), 64'd255);

    // Snapshot of a reset-vector fetch.
    mode = 2'd2; half_period = 16'd2;
    addr_bus = 16'hFFFC; data_bus_in = 8'hEA;
    cc0 = cycle_count;
    step_pulse = 1'b1; tick(1); step_pulse = 1'b0;
    wait_edge(1, 20, "snap_fall");
    chk("snap_valid_hi", 64'(snap_valid), 64'd1);
    chk("snap_addr_fffc", 64'(snap_addr), 64'hFFFC);
    chk("snap_data_ea", 64'(snap_data), 64'hEA);
`ifdef MPU_CYCLE_COUNT_EN
    chk("cycle_count_step", 64'(cycle_count - cc0), 64'd1);
`else
    chk("cycle_count_tied", 64'(cycle_count), 64'd0);
`endif
    addr_bus = 16'h1234; data_bus_in = 8'h55;
    tick(1);
    chk("snap_valid_pulse", 64'(snap_valid), 64'd0);
    chk("snap_addr_held", 64'(snap_addr), 64'hFFFC);

    // Reset in the middle of a high phase.
    half_period = 16'd4; mode = 2'd1;
    wait_edge(0, 20, "rst_rise");
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_clk", 64'(mpu_clk), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_snap_valid", 64'(snap_valid), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_release_clk", 64'(mpu_clk), 64'd0);
    chk("rst_release_busy", 64'(busy), 64'd0);
    mode = 2'd0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
